stack_alu_ctrl: RTL

Stack-machine execution controller that drives the push/pop side of the team's LIFO stack block (push, pop, data_in in; data_out, full, empty out). It accepts one instruction at a time over a valid/ready handshake and sequences the stack commands the instruction needs: immediate push, pop, DUP, and the binary ALU ops ADD/SUB/AND/OR. It tracks stack depth internally, rejects underflow/overflow before touching the stack, and reports each completion with a one-cycle done pulse.

---
 rtl/stack_alu_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stack_alu_ctrl.sv
// stack_alu_ctrl
//   Execution controller for a stack machine. Takes one instruction at a time
//   over a valid/ready handshake and sequences the push/pop commands of an
//   external LIFO: immediate PUSH, POP, DUP and the binary ops ADD/SUB/AND/OR.
//   Depth is tracked internally, so illegal instructions (underflow/overflow)
//   are rejected before any stack command is issued.
//
// Ports
//   clk, asyn_n_rst              clock / async active-low reset (shared with LIFO)
//   instr_valid, instr_ready     instruction handshake (ready only in IDLE)
//   opcode[2:0], imm             instruction, sampled only at accept
//   stk_push, stk_pop            LIFO commands (never high together)
//   stk_data_in                  LIFO write data (res_q while pushing, else 0)
//   stk_data_out                 LIFO read data, registered on the pop edge
//   stk_full, stk_empty          LIFO status, monitored only
//   depth                        entry count 0..STACK_DEPTH
//   done, result, error          completion pulse, last pushed/popped value, reject flag
module stack_alu_ctrl #(
  parameter int DATA_WIDTH  = 6,
  parameter int STACK_DEPTH = 16,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  asyn_n_rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  error
);

  localparam logic [2:0] OP_NOP = 3'b000, OP_PUSH = 3'b001, OP_POP = 3'b010,
                         OP_ADD = 3'b011, OP_SUB  = 3'b100, OP_AND = 3'b101,
                         OP_OR  = 3'b110, OP_DUP  = 3'b111;

  localparam logic [DEPTH_W-1:0] D_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] D_TWO = DEPTH_W'(2);

  typedef enum logic [2:0] {IDLE, POP_A, POP_B, LATCH, PUSH_R, PUSH_R2, DONE} state_t;

  state_t                state, nxt;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] res_q, res_d, opnd_a, opnd_d, alu;
  logic                  err_d, legal, is_bin, accept;

  // Status inputs are observed by the surrounding system only; the controller
  // relies on its own depth count for every decision.
  logic unused_status;
  assign unused_status = stk_full ^ stk_empty;

  assign accept = instr_valid && instr_ready;
  assign is_bin = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_OR);

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OP_PUSH:                       legal = depth < D_MAX;
      OP_POP:                        legal = depth >= D_ONE;
      OP_ADD, OP_SUB, OP_AND, OP_OR: legal = depth >= D_TWO;
      OP_DUP:                        legal = (depth >= D_ONE) && (depth < D_MAX);
      default:                       legal = 1'b1;
    endcase
  end

  // stk_data_out holds the second entry in LATCH; opnd_a holds the top.
  always_comb begin
    case (op_q)
      OP_ADD:  alu = stk_data_out + opnd_a;
      OP_SUB:  alu = stk_data_out - opnd_a;
      OP_AND:  alu = stk_data_out & opnd_a;
      OP_OR:   alu = stk_data_out | opnd_a;
      default: alu = stk_data_out;
    endcase
  end

  always_comb begin
    nxt    = state;
    op_d   = op_q;
    res_d  = res_q;
    opnd_d = opnd_a;
    err_d  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        op_d = opcode;
        if (!legal) begin
          err_d = 1'b1;
          nxt   = DONE;
        end else if (opcode == OP_NOP) begin
          nxt = DONE;
        end else if (opcode == OP_PUSH) begin
          res_d = imm;
          nxt   = PUSH_R;
        end else begin
          nxt = POP_A;
        end
      end
      POP_A:   nxt = is_bin ? POP_B : LATCH;
      POP_B: begin
        opnd_d = stk_data_out;
        nxt    = LATCH;
      end
      LATCH: begin
        res_d = alu;
        nxt   = (op_q == OP_POP) ? DONE : PUSH_R;
      end
      PUSH_R:  nxt = (op_q == OP_DUP) ? PUSH_R2 : DONE;
      PUSH_R2: nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one reflects the
  // state it belongs to without a decode stage after the flops.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state       <= IDLE;
      op_q        <= OP_NOP;
      res_q       <= '0;
      opnd_a      <= '0;
      depth       <= '0;
      instr_ready <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      result      <= '0;
    end else begin
      state       <= nxt;
      op_q        <= op_d;
      res_q       <= res_d;
      opnd_a      <= opnd_d;
      depth       <= depth + DEPTH_W'(stk_push) - DEPTH_W'(stk_pop);
      instr_ready <= (nxt == IDLE);
      stk_push    <= (nxt == PUSH_R) || (nxt == PUSH_R2);
      stk_pop     <= (nxt == POP_A) || (nxt == POP_B);
      stk_data_in <= ((nxt == PUSH_R) || (nxt == PUSH_R2)) ? res_d : '0;
      done        <= (nxt == DONE);
      error       <= (nxt == DONE) && err_d;
      if ((nxt == DONE) && !err_d) result <= res_d;
    end
  end

endmodule
